// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration handshake bus for the pattern detector
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int WIN_W   = 16
) ();
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [WIN_W-1:0]   cfg_window;
  logic               cfg_err;
  modport master (output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_window, output cfg_ready, cfg_err);
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detector with config handshake and bounded runs
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int WIN_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_ctrl_if.slave cfg,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_seq_valid,
  input  logic             i_seq,
  output logic             o_detected,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);
  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [WIN_W-1:0]   r_win;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [WIN_W-1:0]   r_bits;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_done;
  logic               r_err;
  logic               w_acc;
  logic               w_ok;
  logic [MAX_LEN-1:0] w_hist;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill;
  logic [WIN_W-1:0]   w_bits;
  logic               w_match;
  logic               w_last;
  assign cfg.cfg_ready = r_state != RUN;
  assign cfg.cfg_err   = r_err;
  assign o_busy        = r_state == RUN;
  assign o_detected    = r_det;
  assign o_match_count = r_cnt;
  assign o_overflow    = r_ovf;
  assign o_done        = r_done;
  // Next-bit view of history/fill/bit counter and the match against the low cfg_len bits
  always_comb begin
    w_acc   = cfg.cfg_valid & cfg.cfg_ready;
    w_ok    = (cfg.cfg_len != '0) && (cfg.cfg_len <= L_MAX);
    w_hist  = {r_hist[MAX_LEN-2:0], i_seq};
    w_mask  = ~({MAX_LEN{1'b1}} << r_len);
    w_fill  = (r_fill >= L_MAX) ? r_fill : r_fill + 1'b1;
    w_bits  = r_bits + 1'b1;
    w_match = (((w_hist ^ r_pat) & w_mask) == '0) && (w_fill >= r_len);
    w_last  = (r_win != '0) && (w_bits == r_win);
  end
  // Control FSM; a config handshake always takes priority over start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_win   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_det   <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_det <= 1'b0;
      r_err <= w_acc & ~w_ok;
      if (r_state == RUN) begin
        if (i_seq_valid) begin
          r_hist <= w_hist;
          r_bits <= w_bits;
          r_fill <= (w_match && !r_ovl) ? '0 : w_fill;
          if (w_match) begin
            r_det <= 1'b1;
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            r_ovf <= r_ovf | (&r_cnt);
          end
        end
        if (i_stop || (i_seq_valid && w_last)) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end else if (w_acc) begin
        if (w_ok) begin
          r_pat   <= cfg.cfg_pattern;
          r_len   <= cfg.cfg_len;
          r_ovl   <= cfg.cfg_overlap;
          r_win   <= cfg.cfg_window;
          r_state <= ARMED;
          r_done  <= 1'b0;
        end
      end else if (i_start && r_state != IDLE) begin
        r_state <= RUN;
        r_done  <= 1'b0;
        r_hist  <= '0;
        r_fill  <= '0;
        r_bits  <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scenario tests for seq_detect_ctrl
module tb_seq_detect_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_seq_valid = 1'b0;
  logic       i_seq = 1'b0;
  logic       o_detected;
  logic [1:0] o_match_count;
  logic       o_overflow;
  logic       o_busy;
  logic       o_done;
  int         checks = 0;
  int         errors = 0;
  seq_detect_ctrl_if #(.MAX_LEN(8), .LEN_W(4), .WIN_W(16)) ifc ();
  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .WIN_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg(ifc), .i_start(i_start), .i_stop(i_stop),
    .i_seq_valid(i_seq_valid), .i_seq(i_seq), .o_detected(o_detected),
    .o_match_count(o_match_count), .o_overflow(o_overflow), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [15:0] w);
    ifc.cfg_pattern = p;
    ifc.cfg_len = l;
    ifc.cfg_overlap = o;
    ifc.cfg_window = w;
    ifc.cfg_valid = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
  endtask
  task automatic send(input logic b);
    i_seq = b;
    i_seq_valid = 1'b1;
    tick();
    i_seq_valid = 1'b0;
  endtask
  task automatic do_start;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask
  task automatic do_stop;
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask
  task automatic test_reset_state;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (ifc.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ifc.cfg_ready); end
    checks++; if ({o_busy, o_done, o_detected, o_overflow} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {o_busy, o_done, o_detected, o_overflow}); end
    checks++; if (o_match_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", o_match_count); end
  endtask
  task automatic test_non_overlap;
    logic [4:0] stream = 5'b10101;
    logic [4:0] dets = '0;
    send_cfg(8'b101, 4'd3, 1'b0, 16'd5);
    checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL nov_armed: got %b want 00", {o_busy, o_done}); end
    do_start();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL nov_busy: got %b want 1", o_busy); end
    for (int i = 4; i >= 0; i--) begin
      send(stream[i]);
      dets = {dets[3:0], o_detected};
      if (i == 1) begin
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL nov_early_done: got %b want 0", o_done); end
      end
    end
    checks++; if (dets !== 5'b00100) begin errors++; $display("FAIL nov_pulses: got %b want 00100", dets); end
    checks++; if ({o_done, o_busy} !== 2'b10) begin errors++; $display("FAIL nov_done: got %b want 10", {o_done, o_busy}); end
    checks++; if (o_match_count !== 2'd1) begin errors++; $display("FAIL nov_count: got %0d want 1", o_match_count); end
  endtask
  task automatic test_overlap;
    logic [4:0] stream = 5'b10101;
    logic [4:0] dets = '0;
    send_cfg(8'b101, 4'd3, 1'b1, 16'd5);
    checks++; if ({o_done, o_match_count} !== 3'b001) begin errors++; $display("FAIL ov_hold: got %b want 001", {o_done, o_match_count}); end
    do_start();
    checks++; if (o_match_count !== 2'd0) begin errors++; $display("FAIL ov_clear: got %0d want 0", o_match_count); end
    for (int i = 4; i >= 0; i--) begin
      send(stream[i]);
      dets = {dets[3:0], o_detected};
    end
    checks++; if (dets !== 5'b00101) begin errors++; $display("FAIL ov_pulses: got %b want 00101", dets); end
    checks++; if ({o_done, o_detected} !== 2'b11) begin errors++; $display("FAIL ov_last: got %b want 11", {o_done, o_detected}); end
    checks++; if (o_match_count !== 2'd2) begin errors++; $display("FAIL ov_count: got %0d want 2", o_match_count); end
  endtask
  task automatic test_gaps_stop;
    send_cfg(8'b101, 4'd3, 1'b0, 16'd0);
    do_start();
    send(1'b1);
    tick();
    send(1'b0);
    tick();
    checks++; if (o_detected !== 1'b0) begin errors++; $display("FAIL gap_idle_det: got %b want 0", o_detected); end
    tick();
    send(1'b1);
    checks++; if (o_detected !== 1'b1) begin errors++; $display("FAIL gap_det: got %b want 1", o_detected); end
    tick();
    checks++; if ({o_detected, o_busy, o_match_count} !== 4'b0101) begin errors++; $display("FAIL gap_after: got %b want 0101", {o_detected, o_busy, o_match_count}); end
    do_stop();
    checks++; if ({o_done, o_busy} !== 2'b10) begin errors++; $display("FAIL stop_done: got %b want 10", {o_done, o_busy}); end
    send(1'b1);
    send(1'b0);
    send(1'b1);
    checks++; if ({o_detected, o_match_count, o_done} !== 4'b0011) begin errors++; $display("FAIL stop_ignore: got %b want 0011", {o_detected, o_match_count, o_done}); end
  endtask
  task automatic test_saturation;
    logic [5:0] dets = '0;
    send_cfg(8'b1, 4'd1, 1'b1, 16'd6);
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(1'b1);
      dets = {dets[4:0], o_detected};
      if (i == 2) begin
        checks++; if ({o_match_count, o_overflow} !== 3'b110) begin errors++; $display("FAIL sat_third: got %b want 110", {o_match_count, o_overflow}); end
      end
    end
    checks++; if (dets !== 6'b111111) begin errors++; $display("FAIL sat_pulses: got %b want 111111", dets); end
    checks++; if ({o_match_count, o_overflow, o_done} !== 4'b1111) begin errors++; $display("FAIL sat_final: got %b want 1111", {o_match_count, o_overflow, o_done}); end
    do_start();
    checks++; if ({o_match_count, o_overflow, o_busy} !== 4'b0001) begin errors++; $display("FAIL sat_restart: got %b want 0001", {o_match_count, o_overflow, o_busy}); end
    do_stop();
  endtask
  task automatic test_reset;
    logic [4:0] stream = 5'b10101;
    send_cfg(8'b101, 4'd3, 1'b1, 16'd0);
    do_start();
    for (int i = 4; i >= 0; i--) send(stream[i]);
    checks++; if ({o_match_count, o_busy} !== 3'b101) begin errors++; $display("FAIL rrun_pre: got %b want 101", {o_match_count, o_busy}); end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if ({o_detected, o_match_count, o_overflow, o_done, o_busy, ifc.cfg_ready} !== 7'b0000001) begin errors++; $display("FAIL rrun_state: got %b want 0000001", {o_detected, o_match_count, o_overflow, o_done, o_busy, ifc.cfg_ready}); end
    do_start();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rrun_start_ignored: got %b want 0", o_busy); end
  endtask
  task automatic test_config;
    send_cfg(8'b11, 4'd0, 1'b0, 16'd0);
    checks++; if (ifc.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len0_err: got %b want 1", ifc.cfg_err); end
    tick();
    checks++; if (ifc.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", ifc.cfg_err); end
    do_start();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cfg_len0_idle: got %b want 0", o_busy); end
    send_cfg(8'b11, 4'd2, 1'b0, 16'd0);
    checks++; if (ifc.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_legal_err: got %b want 0", ifc.cfg_err); end
    send_cfg(8'b101, 4'd9, 1'b0, 16'd0);
    checks++; if (ifc.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len9_err: got %b want 1", ifc.cfg_err); end
    do_start();
    checks++; if ({o_busy, ifc.cfg_ready} !== 2'b10) begin errors++; $display("FAIL cfg_run_ready: got %b want 10", {o_busy, ifc.cfg_ready}); end
    send_cfg(8'b101, 4'd3, 1'b0, 16'd0);
    send(1'b1);
    send(1'b1);
    checks++; if ({o_detected, o_match_count} !== 3'b101) begin errors++; $display("FAIL cfg_old_kept: got %b want 101", {o_detected, o_match_count}); end
    do_stop();
    send_cfg(8'b1, 4'd1, 1'b1, 16'd0);
    ifc.cfg_pattern = 8'b0;
    ifc.cfg_len = 4'd1;
    ifc.cfg_valid = 1'b1;
    i_start = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
    i_start = 1'b0;
    checks++; if ({o_busy, o_done} !== 2'b00) begin errors++; $display("FAIL cfg_wins: got %b want 00", {o_busy, o_done}); end
    do_start();
    send(1'b0);
    checks++; if (o_detected !== 1'b1) begin errors++; $display("FAIL cfg_new_pat0: got %b want 1", o_detected); end
    send(1'b1);
    checks++; if (o_detected !== 1'b0) begin errors++; $display("FAIL cfg_new_pat1: got %b want 0", o_detected); end
    do_stop();
  endtask
  initial begin
    ifc.cfg_valid = 1'b0;
    ifc.cfg_pattern = '0;
    ifc.cfg_len = '0;
    ifc.cfg_overlap = 1'b0;
    ifc.cfg_window = '0;
    test_reset_state();
    test_non_overlap();
    test_overlap();
    test_gaps_stop();
    test_saturation();
    test_reset();
    test_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
